// File: rtl/sysclk_sync_pkg.sv
// Shared constants and helpers for the sysclk sync generator.
package sysclk_sync_pkg;

    localparam int unsigned REALIGN_CNT_BITS = 8;

    function automatic logic [REALIGN_CNT_BITS-1:0] sat_inc(
        input logic [REALIGN_CNT_BITS-1:0] v
    );
        return (v == {REALIGN_CNT_BITS{1'b1}}) ? v : v + REALIGN_CNT_BITS'(1);
    endfunction

endpackage

// File: rtl/sysclk_sync_if.sv
// Offset-write valid/ready/ack handshake between a host and the sync generator.
interface sysclk_sync_if #(
    parameter int unsigned SBITS = 4,
    parameter int unsigned CBITS = 1
);
    logic             offset_wr_i;
    logic [CBITS-1:0] offset_chan_i;
    logic [SBITS-1:0] offset_dat_i;
    logic             offset_ready_o;
    logic             offset_ack_o;

    modport master (
        output offset_wr_i, offset_chan_i, offset_dat_i,
        input  offset_ready_o, offset_ack_o
    );

    modport slave (
        input  offset_wr_i, offset_chan_i, offset_dat_i,
        output offset_ready_o, offset_ack_o
    );
endinterface

// File: rtl/sysclk_sync_chan.sv
// One delayed sync channel: active offset register and the IOB-packable output flop.
module sysclk_sync_chan #(
    parameter int unsigned SBITS = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic [SBITS-1:0] s_i,
    input  logic             ld_i,
    input  logic [SBITS-1:0] off_i,
    output logic             sync_o
);
    localparam logic [SBITS-1:0] HALF = SBITS'(1) << (SBITS - 1);

    logic [SBITS-1:0] off_q, off_d;
    logic [SBITS-1:0] diff_c;
    logic             sync_q, sync_d;

    // Output uses the offset active in this cycle; a load only affects later edges.
    always_comb begin
        off_d  = off_q;
        if (ld_i) begin
            off_d = off_i;
        end
        diff_c = s_i - off_q;
        sync_d = (diff_c >= HALF);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            off_q  <= '0;
            sync_q <= 1'b0;
        end else begin
            off_q  <= off_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/sysclk_sync_gen.sv
// Sysclk-domain phase/sync generator with realign and boundary-applied per-channel offsets.
module sysclk_sync_gen
    import sysclk_sync_pkg::*;
#(
    parameter int unsigned PHASE_BITS = 3,
    parameter int unsigned NUM_SYNC   = 2
) (
    input  logic                        sysclk,
    input  logic                        reset,
    input  logic                        align_i,
    sysclk_sync_if.slave                off_if,
    output logic [PHASE_BITS-1:0]       sysclk_count_o,
    output logic                        sysclk_phase_o,
    output logic                        sysclk_sync_o,
    output logic [NUM_SYNC-1:0]         sync_o,
    output logic [REALIGN_CNT_BITS-1:0] realign_cnt_o
);
    localparam int unsigned SBITS = PHASE_BITS + 1;
    localparam int unsigned CBITS = $clog2(NUM_SYNC);
    localparam logic [SBITS-1:0] S_MAX = {SBITS{1'b1}};

    logic [SBITS-1:0]            s_q, s_d;
    logic [PHASE_BITS-1:0]       count_q, count_d;
    logic                        phase_q, phase_d;
    logic                        sync_q, sync_d;
    logic [REALIGN_CNT_BITS-1:0] realign_q, realign_d;
    logic                        ready_q, ready_d;
    logic [CBITS-1:0]            pend_chan_q, pend_chan_d;
    logic [SBITS-1:0]            pend_dat_q, pend_dat_d;
    logic                        boundary_c, ack_c;

    // Counter, output registers, realign counting and the offset handshake.
    always_comb begin
        boundary_c  = (s_q == S_MAX) || align_i;
        ack_c       = !ready_q && boundary_c;
        s_d         = align_i ? '0 : s_q + SBITS'(1);
        count_d     = s_q[PHASE_BITS-1:0];
        phase_d     = (s_q[PHASE_BITS-1:0] == '0);
        sync_d      = s_q[SBITS-1];
        realign_d   = realign_q;
        ready_d     = ready_q;
        pend_chan_d = pend_chan_q;
        pend_dat_d  = pend_dat_q;
        if (align_i && (s_q != '0)) begin
            realign_d = sat_inc(realign_q);
        end
        // Accept and apply are exclusive: accept needs ready high, apply needs it low.
        if (ready_q && off_if.offset_wr_i) begin
            ready_d     = 1'b0;
            pend_chan_d = off_if.offset_chan_i;
            pend_dat_d  = off_if.offset_dat_i;
        end else if (ack_c) begin
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            s_q         <= '0;
            count_q     <= '0;
            phase_q     <= 1'b0;
            sync_q      <= 1'b0;
            realign_q   <= '0;
            ready_q     <= 1'b1;
            pend_chan_q <= '0;
            pend_dat_q  <= '0;
        end else begin
            s_q         <= s_d;
            count_q     <= count_d;
            phase_q     <= phase_d;
            sync_q      <= sync_d;
            realign_q   <= realign_d;
            ready_q     <= ready_d;
            pend_chan_q <= pend_chan_d;
            pend_dat_q  <= pend_dat_d;
        end
    end

    for (genvar i = 0; i < NUM_SYNC; i++) begin : g_chan
        sysclk_sync_chan #(
            .SBITS (SBITS)
        ) u_chan (
            .sysclk (sysclk),
            .reset  (reset),
            .s_i    (s_q),
            .ld_i   (ack_c && (pend_chan_q == CBITS'(i))),
            .off_i  (pend_dat_q),
            .sync_o (sync_o[i])
        );
    end

    assign sysclk_count_o        = count_q;
    assign sysclk_phase_o        = phase_q;
    assign sysclk_sync_o         = sync_q;
    assign realign_cnt_o         = realign_q;
    assign off_if.offset_ready_o = ready_q;
    assign off_if.offset_ack_o   = ack_c;

endmodule

// File: tb/tb_sysclk_sync_gen.sv
// Directed bench for sysclk_sync_gen: default build (3,2) plus a (4,3) build.
module tb_sysclk_sync_gen;
    localparam int unsigned PB_A = 3, NS_A = 2, SB_A = 4, CB_A = 1;
    localparam int unsigned PB_B = 4, NS_B = 3, SB_B = 5, CB_B = 2;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #5 sysclk = ~sysclk;

    logic                align_a, align_b;
    logic [PB_A-1:0]     count_a;
    logic [PB_B-1:0]     count_b;
    logic                phase_a, phase_b, sync_a, sync_b;
    logic [NS_A-1:0]     so_a;
    logic [NS_B-1:0]     so_b;
    logic [7:0]          rc_a, rc_b;

    sysclk_sync_if #(.SBITS(SB_A), .CBITS(CB_A)) if_a ();
    sysclk_sync_if #(.SBITS(SB_B), .CBITS(CB_B)) if_b ();

    sysclk_sync_gen #(.PHASE_BITS(PB_A), .NUM_SYNC(NS_A)) dut_a (
        .sysclk (sysclk), .reset (reset), .align_i (align_a), .off_if (if_a),
        .sysclk_count_o (count_a), .sysclk_phase_o (phase_a), .sysclk_sync_o (sync_a),
        .sync_o (so_a), .realign_cnt_o (rc_a)
    );

    sysclk_sync_gen #(.PHASE_BITS(PB_B), .NUM_SYNC(NS_B)) dut_b (
        .sysclk (sysclk), .reset (reset), .align_i (align_b), .off_if (if_b),
        .sysclk_count_o (count_b), .sysclk_phase_o (phase_b), .sysclk_sync_o (sync_b),
        .sync_o (so_b), .realign_cnt_o (rc_b)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    logic        hist [0:4095];
    logic [3:0]  s_a, sp_a;
    logic [4:0]  s_b, sp_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; s_* is the counter value in the cycle now starting, sp_* the previous one.
    task automatic cyc();
        @(posedge sysclk);
        sp_a = s_a;
        sp_b = s_b;
        s_a  = (reset || align_a) ? 4'd0 : s_a + 4'd1;
        s_b  = (reset || align_b) ? 5'd0 : s_b + 5'd1;
        #2;
        cyc_n++;
        hist[cyc_n] = sync_a;
    endtask

    task automatic wait_s_a(input logic [3:0] x);
        int k = 0;
        while (s_a != x && k < 40) begin
            cyc();
            k++;
        end
        check_eq("wait_s", 32'(s_a), 32'(x));
    endtask

    task automatic check_base_a(input string tag);
        check_eq({tag, "_cnt"}, 32'(count_a), 32'(sp_a[2:0]));
        check_eq({tag, "_ph"},  32'(phase_a), 32'(sp_a[2:0] == 3'd0));
        check_eq({tag, "_sy"},  32'(sync_a),  32'(sp_a[3]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_ph, n_hi, n_ack, ack_k, got;
        logic [4:0] ack_s;
        align_a = 1'b0; align_b = 1'b0;
        if_a.offset_wr_i = 1'b0; if_a.offset_chan_i = '0; if_a.offset_dat_i = '0;
        if_b.offset_wr_i = 1'b0; if_b.offset_chan_i = '0; if_b.offset_dat_i = '0;
        s_a = '0; sp_a = '0; s_b = '0; sp_b = '0;

        // Reset state
        repeat (3) @(posedge sysclk);
        #2;
        check_eq("rst_cnt", 32'(count_a), 0);
        check_eq("rst_ph",  32'(phase_a), 0);
        check_eq("rst_sy",  32'(sync_a), 0);
        check_eq("rst_so",  32'(so_a), 0);
        check_eq("rst_rc",  32'(rc_a), 0);
        check_eq("rst_rdy", 32'(if_a.offset_ready_o), 1);
        check_eq("rst_ack", 32'(if_a.offset_ack_o), 0);
        check_eq("rst_rdy_b", 32'(if_b.offset_ready_o), 1);
        reset = 1'b0;
        cyc();
        check_eq("first_ph", 32'(phase_a), 1);
        check_eq("first_sy", 32'(sync_a), 0);
        check_eq("first_ph_b", 32'(phase_b), 1);

        // Free run with zero offsets
        n_ph = 0; n_hi = 0;
        for (int i = 0; i < 32; i++) begin
            cyc();
            check_base_a("def");
            check_eq("def_so", 32'(so_a), 32'({2{sp_a[3]}}));
            n_ph += 32'(phase_a);
            n_hi += 32'(sync_a);
        end
        check_eq("def_nph", 32'(n_ph), 4);
        check_eq("def_nhi", 32'(n_hi), 16);

        // Chan 1 offset 5 written mid-period, applied at S=15
        wait_s_a(4'd4);
        if_a.offset_wr_i = 1'b1; if_a.offset_chan_i = 1'b1; if_a.offset_dat_i = 4'd5;
        #1;
        check_eq("wr1_rdy", 32'(if_a.offset_ready_o), 1);
        cyc();
        if_a.offset_wr_i = 1'b0;
        #1;
        check_eq("wr1_rdy_lo", 32'(if_a.offset_ready_o), 0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (if_a.offset_ack_o) begin
                got = 1;
                break;
            end
            cyc();
            #1;
        end
        check_eq("wr1_ack", 32'(got), 1);
        check_eq("wr1_ack_s", 32'(s_a), 15);
        cyc();
        #1;
        check_eq("wr1_rdy_hi", 32'(if_a.offset_ready_o), 1);
        check_eq("wr1_ack_lo", 32'(if_a.offset_ack_o), 0);
        repeat (10) cyc();
        for (int i = 0; i < 32; i++) begin
            cyc();
            check_eq("lag5_c1", 32'(so_a[1]), 32'(hist[cyc_n - 5]));
            check_eq("lag0_c0", 32'(so_a[0]), 32'(sync_a));
        end

        // Realign: misaligned, aligned, then saturation
        wait_s_a(4'd6);
        align_a = 1'b1;
        cyc();
        align_a = 1'b0;
        check_eq("al_rc1", 32'(rc_a), 1);
        check_eq("al_cnt6", 32'(count_a), 6);
        align_a = 1'b1;
        cyc();
        align_a = 1'b0;
        check_eq("al_ph", 32'(phase_a), 1);
        check_eq("al_sy", 32'(sync_a), 0);
        check_eq("al_cnt0", 32'(count_a), 0);
        check_eq("al_rc_keep", 32'(rc_a), 1);
        for (int i = 0; i < 300; i++) begin
            cyc();
            align_a = 1'b1;
            cyc();
            align_a = 1'b0;
            if (i == 99) check_eq("al_rc101", 32'(rc_a), 101);
        end
        check_eq("al_rc_sat", 32'(rc_a), 255);

        // Write accepted on a boundary waits a full period; write while busy is dropped
        wait_s_a(4'd15);
        if_a.offset_wr_i = 1'b1; if_a.offset_chan_i = 1'b0; if_a.offset_dat_i = 4'd3;
        #1;
        check_eq("bw_noack", 32'(if_a.offset_ack_o), 0);
        cyc();
        if_a.offset_chan_i = 1'b1; if_a.offset_dat_i = 4'd9;
        #1;
        check_eq("drop_rdy", 32'(if_a.offset_ready_o), 0);
        cyc();
        if_a.offset_wr_i = 1'b0;
        n_ack = 0; ack_k = -1;
        for (int k = 2; k <= 20; k++) begin
            #1;
            if (if_a.offset_ack_o) begin
                n_ack++;
                ack_k = k;
            end
            cyc();
        end
        check_eq("bw_nack", 32'(n_ack), 1);
        check_eq("bw_ack_k", 32'(ack_k), 16);
        repeat (4) cyc();
        for (int i = 0; i < 16; i++) begin
            cyc();
            check_eq("lag3_c0", 32'(so_a[0]), 32'(hist[cyc_n - 3]));
            check_eq("lag5_keep", 32'(so_a[1]), 32'(hist[cyc_n - 5]));
        end

        // Align while a write is pending applies it in the align cycle
        wait_s_a(4'd3);
        if_a.offset_wr_i = 1'b1; if_a.offset_chan_i = 1'b0; if_a.offset_dat_i = 4'd0;
        cyc();
        if_a.offset_wr_i = 1'b0;
        cyc();
        #1;
        check_eq("alp_noack", 32'(if_a.offset_ack_o), 0);
        align_a = 1'b1;
        #1;
        check_eq("alp_ack", 32'(if_a.offset_ack_o), 1);
        cyc();
        align_a = 1'b0;
        #1;
        check_eq("alp_rdy", 32'(if_a.offset_ready_o), 1);
        check_eq("alp_ack_lo", 32'(if_a.offset_ack_o), 0);
        check_eq("alp_rc", 32'(rc_a), 255);
        repeat (3) cyc();
        for (int i = 0; i < 8; i++) begin
            cyc();
            check_eq("alp_lag0", 32'(so_a[0]), 32'(sync_a));
        end

        // Reset while a write is pending
        wait_s_a(4'd2);
        if_a.offset_wr_i = 1'b1; if_a.offset_chan_i = 1'b1; if_a.offset_dat_i = 4'd2;
        cyc();
        if_a.offset_wr_i = 1'b0;
        #1;
        check_eq("rp_pend", 32'(if_a.offset_ready_o), 0);
        reset = 1'b1;
        #1;
        check_eq("rp_rdy", 32'(if_a.offset_ready_o), 1);
        check_eq("rp_ack", 32'(if_a.offset_ack_o), 0);
        check_eq("rp_rc", 32'(rc_a), 0);
        check_eq("rp_so", 32'(so_a), 0);
        check_eq("rp_cnt", 32'(count_a), 0);
        s_a = '0; s_b = '0;
        cyc();
        reset = 1'b0;

        // Both builds after release; the (4,3) build takes a write to channel 3
        if_b.offset_wr_i = 1'b1; if_b.offset_chan_i = 2'd3; if_b.offset_dat_i = 5'd7;
        n_ph = 0; n_ack = 0; ack_s = '0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if_b.offset_wr_i = 1'b0;
            #1;
            check_base_a("rp");
            check_eq("rp_so_run", 32'(so_a), 32'({2{sp_a[3]}}));
            check_eq("rp_ack_a", 32'(if_a.offset_ack_o), 0);
            check_eq("b_ph", 32'(phase_b), 32'(sp_b[3:0] == 4'd0));
            check_eq("b_so", 32'(so_b), 32'({3{sp_b[4]}}));
            if (if_b.offset_ack_o) begin
                n_ack++;
                ack_s = s_b;
            end
            if (k < 32) n_ph += 32'(phase_b);
        end
        check_eq("b_nph", 32'(n_ph), 2);
        check_eq("b_nack", 32'(n_ack), 1);
        check_eq("b_ack_s", 32'(ack_s), 31);
        check_eq("b_rdy", 32'(if_b.offset_ready_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
